// File: rtl/awg_pkg.sv
// Shared wave codes, generator field widths and sequencer FSM encoding for the AWG segment sequencer.
package awg_pkg;

    localparam int WAVE_W  = 5;
    localparam int FREQ_W  = 12;
    localparam int AMP_W   = 3;
    localparam int PHASE_W = 8;

    localparam logic [WAVE_W-1:0] WAVE_SAW  = 5'd0;
    localparam logic [WAVE_W-1:0] WAVE_TRI  = 5'd1;
    localparam logic [WAVE_W-1:0] WAVE_SQR  = 5'd2;
    localparam logic [WAVE_W-1:0] WAVE_SIN  = 5'd3;
    localparam logic [WAVE_W-1:0] WAVE_MUTE = 5'd10;

    // Cycles of forced mute between segments when blanking is built in.
    localparam int BLANK_CYC = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_BLANK = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic [WAVE_W-1:0]  wave;
        logic [FREQ_W-1:0]  freq;
        logic [AMP_W-1:0]   amp;
        logic [PHASE_W-1:0] phase;
    } gen_cfg_t;

    localparam gen_cfg_t GEN_MUTE = {WAVE_MUTE, {FREQ_W{1'b0}}, {AMP_W{1'b0}}, {PHASE_W{1'b0}}};

endpackage

// File: rtl/awg_dwell_timer.sv
// Loadable down counter with zero flag; the caller loads the full dwell*prescale product minus one.
module awg_dwell_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/awg_seq_ctrl.sv
// Segment sequencer that plays a programmed table of generator settings, once or looped, then mutes.
// Optional build macro AWG_SEQ_BLANK_EN inserts a 16-cycle forced-mute BLANK state between segments.
module awg_seq_ctrl
    import awg_pkg::*;
#(
    parameter int  DEPTH    = 8,
    parameter int  TICK_DIV = 50000,
    parameter int  DWELL_W  = 16,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [WAVE_W-1:0]  cfg_wave,
    input  logic [FREQ_W-1:0]  cfg_freq,
    input  logic [AMP_W-1:0]   cfg_amp,
    input  logic [PHASE_W-1:0] cfg_phase,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [AW:0]        num_seg,
    input  logic               loop_en,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [AW-1:0]      seg_idx,
    output logic [WAVE_W-1:0]  state,
    output logic [FREQ_W-1:0]  state_freq,
    output logic [AMP_W-1:0]   state_amp,
    output logic [PHASE_W-1:0] state_phase,
    output logic [2:0]         dbg_state
);

    localparam int CNT_W = DWELL_W + $clog2(TICK_DIV) + 1;

    seq_state_e   state_q, state_d;
    gen_cfg_t     gen_q, gen_d;
    logic [AW-1:0] seg_idx_q, seg_idx_d;
    logic [AW-1:0] cur_idx_q, cur_idx_d;
    logic [AW:0]  num_q, num_d;
    logic         loop_q, loop_d;
    logic         done_q, done_d;
    logic         err_q, err_d;

    gen_cfg_t           tbl_cfg_mem   [DEPTH];
    logic [DWELL_W-1:0] tbl_dwell_mem [DEPTH];

    logic [DWELL_W-1:0] rd_dwell;
    logic [DWELL_W-1:0] eff_dwell;
    logic [CNT_W-1:0]   seg_ticks;
    logic [CNT_W-1:0]   tmr_val;
    logic               tmr_load;
    logic               tmr_zero;
    logic               last_seg;
    logic               advance;

    assign busy = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_BLANK);

    // The table only accepts writes while no sequence is reading it.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy) begin
            tbl_cfg_mem[cfg_addr]   <= {cfg_wave, cfg_freq, cfg_amp, cfg_phase};
            tbl_dwell_mem[cfg_addr] <= cfg_dwell;
        end
    end

    assign rd_dwell  = tbl_dwell_mem[seg_idx_q];
    assign eff_dwell = (rd_dwell == '0) ? DWELL_W'(1) : rd_dwell;
    assign seg_ticks = CNT_W'(eff_dwell) * CNT_W'(TICK_DIV) - CNT_W'(1);
    assign last_seg  = ({1'b0, seg_idx_q} >= (num_q - 1'b1));

    awg_dwell_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // start/stop are levels: start is taken only in IDLE, stop aborts LOAD/RUN/BLANK and wins over start.
    always_comb begin
        state_d   = state_q;
        gen_d     = gen_q;
        seg_idx_d = seg_idx_q;
        cur_idx_d = cur_idx_q;
        num_d     = num_q;
        loop_d    = loop_q;
        done_d    = 1'b0;
        err_d     = cfg_we && busy;
        tmr_load  = 1'b0;
        tmr_val   = seg_ticks;
        advance   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (num_seg != '0) begin
                        num_d     = num_seg;
                        loop_d    = loop_en;
                        seg_idx_d = '0;
                        cur_idx_d = '0;
                        state_d   = ST_LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (stop) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    gen_d     = tbl_cfg_mem[seg_idx_q];
                    cur_idx_d = seg_idx_q;
                    tmr_load  = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (tmr_zero) begin
                    if (!last_seg) begin
                        seg_idx_d = seg_idx_q + 1'b1;
                        advance   = 1'b1;
                    end else if (loop_q) begin
                        seg_idx_d = '0;
                        advance   = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
                if (advance) begin
`ifdef AWG_SEQ_BLANK_EN
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(BLANK_CYC - 1);
                    state_d  = ST_BLANK;
`else
                    state_d  = ST_LOAD;
`endif
                end
            end
`ifdef AWG_SEQ_BLANK_EN
            ST_BLANK: begin
                if (stop) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (tmr_zero) begin
                    state_d = ST_LOAD;
                end
            end
`endif
            ST_DONE: begin
                gen_d   = GEN_MUTE;
                state_d = ST_IDLE;
            end
            default: begin
                gen_d   = GEN_MUTE;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gen_q     <= GEN_MUTE;
            seg_idx_q <= '0;
            cur_idx_q <= '0;
            num_q     <= '0;
            loop_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gen_q     <= gen_d;
            seg_idx_q <= seg_idx_d;
            cur_idx_q <= cur_idx_d;
            num_q     <= num_d;
            loop_q    <= loop_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

`ifdef AWG_SEQ_BLANK_EN
    assign state = (state_q == ST_BLANK) ? WAVE_MUTE : gen_q.wave;
`else
    assign state = gen_q.wave;
`endif
    assign state_freq  = gen_q.freq;
    assign state_amp   = gen_q.amp;
    assign state_phase = gen_q.phase;
    assign seg_idx     = cur_idx_q;
    assign done        = done_q;
    assign cfg_err     = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_awg_seq_ctrl.sv
// Directed bench for awg_seq_ctrl with TICK_DIV=4; blank-state scenario runs when AWG_SEQ_BLANK_EN is defined.
module tb_awg_seq_ctrl;

    localparam int DEPTH    = 8;
    localparam int TICK_DIV = 4;
    localparam int DWELL_W  = 16;
`ifdef AWG_SEQ_BLANK_EN
    localparam int BLANK = 16;
`else
    localparam int BLANK = 0;
`endif
    localparam int PERIOD = TICK_DIV + 1 + BLANK;

    logic        clk, rst_n, cfg_we;
    logic [2:0]  cfg_addr;
    logic [4:0]  cfg_wave;
    logic [11:0] cfg_freq;
    logic [2:0]  cfg_amp;
    logic [7:0]  cfg_phase;
    logic [15:0] cfg_dwell;
    logic [3:0]  num_seg;
    logic        loop_en, start, stop;
    logic        busy, done, cfg_err;
    logic [2:0]  seg_idx;
    logic [4:0]  state;
    logic [11:0] state_freq;
    logic [2:0]  state_amp;
    logic [7:0]  state_phase;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    awg_seq_ctrl #(
        .DEPTH    (DEPTH),
        .TICK_DIV (TICK_DIV),
        .DWELL_W  (DWELL_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wave    (cfg_wave),
        .cfg_freq    (cfg_freq),
        .cfg_amp     (cfg_amp),
        .cfg_phase   (cfg_phase),
        .cfg_dwell   (cfg_dwell),
        .num_seg     (num_seg),
        .loop_en     (loop_en),
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .seg_idx     (seg_idx),
        .state       (state),
        .state_freq  (state_freq),
        .state_amp   (state_amp),
        .state_phase (state_phase),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [4:0] w, input logic [11:0] f,
                               input logic [2:0] am, input logic [7:0] p, input logic [15:0] d);
        cfg_addr = a; cfg_wave = w; cfg_freq = f; cfg_amp = am; cfg_phase = p; cfg_dwell = d;
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || done || state !== 5'd10) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%0b done=%0b state=%0d, required idle within 200 cycles", name, busy, done, state);
        end
    endtask

    // scenarios
    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({state, state_freq, state_amp, state_phase, busy, done, cfg_err, seg_idx} !==
            {5'd10, 12'd0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_outputs: state=%0d freq=%0d amp=%0d phase=%0d busy=%0b done=%0b err=%0b idx=%0d, required 10/0/0/0/0/0/0/0",
                     state, state_freq, state_amp, state_phase, busy, done, cfg_err, seg_idx);
        end
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        write_entry(3'd0, 5'd1, 12'd100, 3'd3, 8'd0, 16'd2);
        num_seg = 4'd1; loop_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || state !== 5'd10) begin
            errors++;
            $display("FAIL single_load: busy=%0b state=%0d, required busy=1 state=10", busy, state);
        end
        tick();
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (state !== 5'd1 || state_freq !== 12'd100 || state_amp !== 3'd3 ||
                done !== (i == 8) || busy !== (i != 8)) begin
                errors++;
                $display("FAIL single_play cycle %0d: state=%0d freq=%0d amp=%0d done=%0b busy=%0b, required 1/100/3/%0b/%0b",
                         i, state, state_freq, state_amp, done, busy, (i == 8), (i != 8));
            end
            tick();
        end
        checks++;
        if (state !== 5'd10 || state_freq !== 12'd0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_end: state=%0d freq=%0d done=%0b busy=%0b, required 10/0/0/0", state, state_freq, done, busy);
        end
    endtask

    task automatic test_loop_stop();
        logic [4:0]  exp_wave [3];
        logic [11:0] exp_freq [3];
        int idx;
        exp_wave[0] = 5'd0; exp_wave[1] = 5'd2; exp_wave[2] = 5'd3;
        exp_freq[0] = 12'd10; exp_freq[1] = 12'd20; exp_freq[2] = 12'd30;
        write_entry(3'd0, 5'd0, 12'd10, 3'd1, 8'd0, 16'd1);
        write_entry(3'd1, 5'd2, 12'd20, 3'd2, 8'd5, 16'd1);
        write_entry(3'd2, 5'd3, 12'd30, 3'd4, 8'd9, 16'd1);
        num_seg = 4'd3; loop_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            idx = k % 3;
            checks++;
            if (state !== exp_wave[idx] || state_freq !== exp_freq[idx] || seg_idx !== 3'(idx)) begin
                errors++;
                $display("FAIL loop_first seg %0d: state=%0d freq=%0d idx=%0d, required %0d/%0d/%0d",
                         k, state, state_freq, seg_idx, exp_wave[idx], exp_freq[idx], idx);
            end
            repeat (PERIOD - 1) tick();
            checks++;
            if (state !== exp_wave[idx] || seg_idx !== 3'(idx) || busy !== 1'b1) begin
                errors++;
                $display("FAIL loop_last seg %0d: state=%0d idx=%0d busy=%0b, required %0d/%0d/1",
                         k, state, seg_idx, busy, exp_wave[idx], idx);
            end
            tick();
        end
        checks++;
        if (state !== 5'd2 || seg_idx !== 3'd1) begin
            errors++;
            $display("FAIL loop_wrap: state=%0d idx=%0d, required 2/1", state, seg_idx);
        end
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_done: done=%0b busy=%0b, required 1/0", done, busy);
        end
        tick();
        checks++;
        if (state !== 5'd10 || state_freq !== 12'd0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_mute: state=%0d freq=%0d done=%0b busy=%0b, required 10/0/0/0", state, state_freq, done, busy);
        end
    endtask

    task automatic test_dwell_zero();
        int n;
        write_entry(3'd0, 5'd3, 12'd55, 3'd2, 8'd7, 16'd0);
        num_seg = 4'd1; loop_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n = 0;
        while (state === 5'd3 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n !== TICK_DIV + 1 || state !== 5'd10) begin
            errors++;
            $display("FAIL dwell_zero_len: cycles=%0d end_state=%0d, required %0d/10", n, state, TICK_DIV + 1);
        end
    endtask

    task automatic test_write_busy();
        num_seg = 4'd1; loop_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        cfg_addr = 3'd0; cfg_wave = 5'd2; cfg_freq = 12'd999; cfg_amp = 3'd7; cfg_phase = 8'd1; cfg_dwell = 16'd7;
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL cfg_err_pulse: cfg_err=%0b, required 1", cfg_err);
        end
        tick();
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_once: cfg_err=%0b, required 0", cfg_err);
        end
        wait_idle("write_busy_run1");
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (state !== 5'd3 || state_freq !== 12'd55 || state_amp !== 3'd2 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL table_unchanged: state=%0d freq=%0d amp=%0d err=%0b, required 3/55/2/0", state, state_freq, state_amp, cfg_err);
        end
        wait_idle("write_busy_run2");
    endtask

    task automatic test_num_zero_and_conflict();
        num_seg = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL num_zero_done: done=%0b busy=%0b, required 1/0", done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || state !== 5'd10) begin
            errors++;
            $display("FAIL num_zero_after: done=%0b busy=%0b state=%0d, required 0/0/10", done, busy, state);
        end
        num_seg = 4'd1; start = 1'b1; stop = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || state !== 5'd10) begin
            errors++;
            $display("FAIL start_stop_idle: busy=%0b done=%0b state=%0d, required 0/0/10", busy, done, state);
        end
        start = 1'b0; stop = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        logic saw_done;
        write_entry(3'd0, 5'd1, 12'd100, 3'd3, 8'd4, 16'd2);
        num_seg = 4'd1; loop_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (state !== 5'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_run: state=%0d busy=%0b, required 1/1", state, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({state, state_freq, state_amp, state_phase, busy, done, seg_idx} !==
            {5'd10, 12'd0, 3'd0, 8'd0, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL async_reset_mute: state=%0d freq=%0d amp=%0d phase=%0d busy=%0b done=%0b idx=%0d, required 10/0/0/0/0/0/0",
                     state, state_freq, state_amp, state_phase, busy, done, seg_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0 || state !== 5'd10) begin
            errors++;
            $display("FAIL reset_no_done: activity=%0b state=%0d, required 0/10", saw_done, state);
        end
    endtask

`ifdef AWG_SEQ_BLANK_EN
    task automatic test_blank();
        int  n;
        logic bad_hold;
        write_entry(3'd0, 5'd1, 12'd40, 3'd2, 8'd3, 16'd1);
        write_entry(3'd1, 5'd2, 12'd80, 3'd1, 8'd6, 16'd1);
        num_seg = 4'd2; loop_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (TICK_DIV) tick();
        n = 0;
        bad_hold = 1'b0;
        while (state === 5'd10 && n < 40) begin
            if (state_freq !== 12'd40 || state_amp !== 3'd2 || state_phase !== 8'd3) bad_hold = 1'b1;
            n++;
            tick();
        end
        checks++;
        if (n !== 16 || bad_hold !== 1'b0) begin
            errors++;
            $display("FAIL blank_len: mute_cycles=%0d hold_err=%0b, required 16/0", n, bad_hold);
        end
        tick();
        checks++;
        if (state !== 5'd2 || state_freq !== 12'd80 || seg_idx !== 3'd1) begin
            errors++;
            $display("FAIL blank_next_seg: state=%0d freq=%0d idx=%0d, required 2/80/1", state, state_freq, seg_idx);
        end
        wait_idle("blank");
    endtask
`endif

    // main sequence and final report
    initial begin
        cfg_we = 1'b0; cfg_addr = '0; cfg_wave = '0; cfg_freq = '0; cfg_amp = '0; cfg_phase = '0; cfg_dwell = '0;
        num_seg = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
        test_reset();
        test_single();
        test_loop_stop();
        test_dwell_zero();
        test_write_busy();
        test_num_zero_and_conflict();
`ifdef AWG_SEQ_BLANK_EN
        test_blank();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
